// File: rtl/simple_ctrl_pkg.sv
// simple_ctrl_decoder shared types: opcodes, state encoding,
// instruction field positions and the ALU operation map.
package simple_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_LDI  = 3'd6,
        OP_HALT = 3'd7
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD_A = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_WB     = 3'd3;
    localparam state_t ST_HALTED = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 13;
    localparam int RD_HI    = 12;
    localparam int RD_LO    = 11;
    localparam int RS_HI    = 10;
    localparam int RS_LO    = 9;
    localparam int RSVD_BIT = 8;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    function automatic logic [2:0] alu_map(op_e op);
        logic [2:0] sel;
        sel = ALU_ADD;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_XOR:  sel = ALU_XOR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/simple_ctrl_decoder_if.sv
// Instruction handshake between the instruction source and
// simple_ctrl_decoder.
interface simple_ctrl_decoder_if #(
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/simple_ctrl_fsm.sv
// Control sequencer: state register and next-state logic for
// the IDLE / LOAD_A / EXEC / WB / HALTED instruction flow.
import simple_ctrl_pkg::*;

module simple_ctrl_fsm (
    input  logic   clk,
    input  logic   rst,
    input  logic   accept,
    input  op_e    op,
    output state_t state
);

    state_t state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_NOP:  state_nx = ST_IDLE;
                        OP_LDI:  state_nx = ST_WB;
                        OP_HALT: state_nx = ST_HALTED;
                        default: state_nx = ST_LOAD_A;
                    endcase
                end
            end
            ST_LOAD_A: state_nx = ST_EXEC;
            ST_EXEC:   state_nx = ST_WB;
            ST_WB:     state_nx = ST_IDLE;
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

endmodule

// File: rtl/simple_ctrl_decoder.sv
// Multi-cycle instruction decoder: latches an accepted instruction
// and sequences RF / accumulator / ALU strobes for the datapath.
import simple_ctrl_pkg::*;

module simple_ctrl_decoder #(
    parameter int INSTR_W   = 16,
    parameter int RF_ADDR_W = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    simple_ctrl_decoder_if.slave bus,
    output logic [RF_ADDR_W-1:0] RF_addr,
    output logic                 RF_we,
    output logic                 A_re,
    output logic                 ALU_ce,
    output logic [2:0]           ALU_opcode_wire,
    output logic                 imm_sel,
    output logic [7:0]           imm_out,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired
);

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic               accept;
    op_e                in_op;
    op_e                ir_op;
    logic               unused_rsvd;

    assign bus.instr_ready = (state == ST_IDLE);
    assign accept = bus.instr_valid && bus.instr_ready;
    assign in_op  = op_e'(bus.instr[OP_HI:OP_LO]);
    assign ir_op  = op_e'(ir[OP_HI:OP_LO]);
    assign unused_rsvd = ir[RSVD_BIT];

    simple_ctrl_fsm u_fsm (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .op     (in_op),
        .state  (state)
    );

    // Latch only on accept so the operands stay fixed mid-operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir <= '0;
        end else if (accept) begin
            ir <= bus.instr;
        end
    end

    // NOP/HALT retire at acceptance; everything else on leaving WB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if ((state == ST_WB) ||
                     (accept && (in_op == OP_NOP ||
                                 in_op == OP_HALT))) begin
            retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        RF_addr         = '0;
        RF_we           = 1'b0;
        A_re            = 1'b0;
        ALU_ce          = 1'b0;
        ALU_opcode_wire = ALU_ADD;
        imm_sel         = 1'b0;
        imm_out         = '0;
        halted          = 1'b0;
        unique case (1'b1)
            (state == ST_LOAD_A): begin
                A_re    = 1'b1;
                RF_addr = ir[RS_HI:RS_LO];
            end
            (state == ST_EXEC): begin
                ALU_ce          = 1'b1;
                ALU_opcode_wire = alu_map(ir_op);
                RF_addr         = ir[RD_HI:RD_LO];
            end
            (state == ST_WB): begin
                RF_we   = 1'b1;
                RF_addr = ir[RD_HI:RD_LO];
                if (ir_op == OP_LDI) begin
                    imm_sel = 1'b1;
                    imm_out = ir[IMM_HI:IMM_LO];
                end
            end
            (state == ST_HALTED): begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_simple_ctrl_decoder.sv
// Self-checking bench for simple_ctrl_decoder: directed cases plus
// random instruction streams against a per-cycle schedule model.
module tb_simple_ctrl_decoder;

    logic        clk;
    logic        rst;
    logic [1:0]  RF_addr;
    logic        RF_we;
    logic        A_re;
    logic        ALU_ce;
    logic [2:0]  ALU_opcode_wire;
    logic        imm_sel;
    logic [7:0]  imm_out;
    logic        halted;
    logic [15:0] retired;

    simple_ctrl_decoder_if #(.INSTR_W(16)) bus ();

    simple_ctrl_decoder dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .RF_addr         (RF_addr),
        .RF_we           (RF_we),
        .A_re            (A_re),
        .ALU_ce          (ALU_ce),
        .ALU_opcode_wire (ALU_opcode_wire),
        .imm_sel         (imm_sel),
        .imm_out         (imm_out),
        .halted          (halted),
        .retired         (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a_re;
        logic       alu_ce;
        logic       rf_we;
        logic [1:0] addr;
        logic [2:0] opc;
        logic       imm_sel;
        logic [7:0] imm;
        bit         last;
    } rec_t;

    rec_t        q[$];
    bit          m_halted;
    logic [15:0] m_ret;
    int          n_chk;
    int          n_fail;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t mk(logic a, logic c, logic w, logic [1:0] ad,
                                logic [2:0] o, logic s, logic [7:0] im,
                                bit l);
        rec_t r;
        r.a_re = a; r.alu_ce = c; r.rf_we = w; r.addr = ad;
        r.opc = o; r.imm_sel = s; r.imm = im; r.last = l;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_halted = 1'b0;
        m_ret = '0;
    endtask

    // Expand an accepted instruction into its per-cycle strobe schedule.
    task automatic model_edge(bit v, logic [15:0] i);
        bit   rdy;
        rec_t r;
        int   op;
        rdy = !m_halted && (q.size() == 0);
        if (q.size() != 0) begin
            r = q.pop_front();
            if (r.last) m_ret = m_ret + 16'd1;
        end
        if (rdy && v) begin
            op = int'(i[15:13]);
            if (op == 0) begin
                m_ret = m_ret + 16'd1;
            end else if (op == 7) begin
                m_ret = m_ret + 16'd1;
                m_halted = 1'b1;
            end else if (op == 6) begin
                q.push_back(mk(0, 0, 1, i[12:11], 3'd0, 1, i[7:0], 1));
            end else begin
                q.push_back(mk(1, 0, 0, i[10:9], 3'd0, 0, 8'd0, 0));
                q.push_back(mk(0, 1, 0, i[12:11], 3'(op - 1), 0, 8'd0, 0));
                q.push_back(mk(0, 0, 1, i[12:11], 3'd0, 0, 8'd0, 1));
            end
        end
    endtask

    task automatic check_outputs();
        rec_t e;
        if (q.size() != 0) e = q[0];
        else e = mk(0, 0, 0, 2'd0, 3'd0, 0, 8'd0, 0);
        chk("ready", bus.instr_ready, !m_halted && (q.size() == 0));
        chk("a_re", A_re, e.a_re);
        chk("alu_ce", ALU_ce, e.alu_ce);
        chk("rf_we", RF_we, e.rf_we);
        chk("rf_addr", RF_addr, e.addr);
        chk("alu_op", ALU_opcode_wire, e.opc);
        chk("imm_sel", imm_sel, e.imm_sel);
        chk("imm_out", imm_out, e.imm);
        chk("halted", halted, m_halted);
        chk("retired", retired, m_ret);
        chk("excl", ($countones({A_re, ALU_ce, RF_we}) <= 1), 1);
    endtask

    task automatic cyc(bit v, logic [15:0] i);
        bus.instr_valid = v;
        bus.instr = i;
        @(posedge clk);
        model_edge(v, i);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs();
    endtask

    logic [15:0] w;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        model_reset();
        #2;

        do_reset();
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_ret", retired, 0);

        cyc(1, 16'h3200);
        chk("add_a_re", A_re, 1);
        chk("add_rs", RF_addr, 1);
        cyc(0, 16'h0);
        chk("add_ce", ALU_ce, 1);
        chk("add_rd", RF_addr, 2);
        cyc(0, 16'h0);
        chk("add_we", RF_we, 1);
        cyc(0, 16'h0);
        chk("add_ready", bus.instr_ready, 1);
        chk("add_ret", retired, 1);

        cyc(1, 16'hD8A5);
        chk("ldi_we", RF_we, 1);
        chk("ldi_addr", RF_addr, 3);
        chk("ldi_imm", imm_out, 8'hA5);
        cyc(0, 16'h0);
        chk("ldi_ready", bus.instr_ready, 1);
        chk("ldi_ret", retired, 2);

        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 16'h0000);
        chk("nop_ret", retired, 4);
        cyc(1, 16'hE000);
        chk("halt_h", halted, 1);
        chk("halt_rdy", bus.instr_ready, 0);
        for (int k = 0; k < 3; k++) cyc(1, 16'hA6A5);
        chk("halt_ret", retired, 5);

        do_reset();
        cyc(1, 16'h5A00);
        cyc(0, 16'h0);
        chk("sub_ce", ALU_ce, 1);
        chk("sub_op", ALU_opcode_wire, 3'b001);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_ce", ALU_ce, 0);
        chk("arst_we", RF_we, 0);
        chk("arst_rdy", bus.instr_ready, 1);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs();
        chk("arst_ret", retired, 0);

        for (int k = 0; k < 600; k++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'd7 && $urandom_range(0, 5) != 0) w[15:13] = 3'd0;
            if (m_halted && $urandom_range(0, 4) == 0) do_reset();
            cyc($urandom_range(0, 3) != 0, w);
        end

        do_reset();
        for (int k = 0; k < 65535; k++) begin
            w = 16'($urandom);
            w[15:13] = 3'd0;
            cyc(1, w);
        end
        chk("wrap_max", retired, 16'hFFFF);
        cyc(1, 16'h0100);
        chk("wrap_zero", retired, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
